// File: rtl/spike_train_decoder.sv
// Spike train decoder: rising-edge spike events, windowed rate with valid/ready, and inter-spike interval.
// Optional ISI path is built only when SPIKE_DEC_ISI_EN is defined.
module spike_train_decoder #(
   parameter int unsigned WIN_CYCLES = 256,
   parameter int unsigned RATE_W     = 8,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              spike_in,
   output logic [RATE_W-1:0] rate_out,
   output logic              rate_valid,
   input  logic              rate_ready,
   output logic              rate_drop,
   output logic [CNT_W-1:0]  isi_out,
   output logic              isi_valid,
   output logic              isi_sat
);

   localparam int unsigned     WIN_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
   localparam logic [RATE_W-1:0] RATE_MAX = '1;

   logic              spike_q;
   logic              evt;
   logic              win_end;
   logic              transfer;
   logic [WIN_W-1:0]  win_cnt;
   logic [RATE_W-1:0] evt_cnt;
   logic [RATE_W-1:0] evt_sum;

   assign evt      = spike_in & ~spike_q & enable;
   assign win_end  = enable & (win_cnt == WIN_LAST);
   assign transfer = rate_valid & rate_ready;
   // Event count including this cycle's event, saturating
   assign evt_sum  = (evt && (evt_cnt != RATE_MAX)) ? evt_cnt + RATE_W'(1) : evt_cnt;

   // Edge-detect history tracks the line even while disabled
   always_ff @(posedge clk) begin
      if (reset) spike_q <= 1'b0;
      else       spike_q <= spike_in;
   end

   // Rate window counters and result handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt    <= '0;
         evt_cnt    <= '0;
         rate_out   <= '0;
         rate_valid <= 1'b0;
         rate_drop  <= 1'b0;
      end else begin
         if (enable) begin
            if (win_end) begin
               win_cnt <= '0;
               evt_cnt <= '0;
            end else begin
               win_cnt <= win_cnt + WIN_W'(1);
               evt_cnt <= evt_sum;
            end
         end
         if (win_end) begin
            rate_out   <= evt_sum;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) rate_drop <= 1'b1;
         end else if (transfer) begin
            rate_valid <= 1'b0;
         end
      end
   end

`ifdef SPIKE_DEC_ISI_EN
   localparam logic [0:0]       S_IDLE  = 1'b0;
   localparam logic [0:0]       S_ARMED = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [CNT_W-1:0] isi_cnt_q;
   logic [CNT_W-1:0] isi_cnt_d;
   logic [CNT_W-1:0] isi_out_d;
   logic             isi_valid_d;
   logic             isi_sat_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         isi_cnt_q <= '0;
         isi_out   <= '0;
         isi_valid <= 1'b0;
         isi_sat   <= 1'b0;
      end else begin
         state_q   <= state_d;
         isi_cnt_q <= isi_cnt_d;
         isi_out   <= isi_out_d;
         isi_valid <= isi_valid_d;
         isi_sat   <= isi_sat_d;
      end
   end

   // Interval measurement: first event arms, later events report and restart
   always_comb begin
      state_d     = state_q;
      isi_cnt_d   = isi_cnt_q;
      isi_out_d   = isi_out;
      isi_valid_d = 1'b0;
      isi_sat_d   = isi_sat;
      if (enable) begin
         if (state_q == S_IDLE) begin
            if (evt) begin
               state_d   = S_ARMED;
               isi_cnt_d = CNT_W'(1);
            end
         end else begin
            if (evt) begin
               isi_out_d   = isi_cnt_q;
               isi_valid_d = 1'b1;
               isi_sat_d   = (isi_cnt_q == CNT_MAX);
               isi_cnt_d   = CNT_W'(1);
            end else if (isi_cnt_q != CNT_MAX) begin
               isi_cnt_d = isi_cnt_q + CNT_W'(1);
            end
         end
      end
   end
`else
   assign isi_out   = '0;
   assign isi_valid = 1'b0;
   assign isi_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_spike_train_decoder.sv
// Self-checking bench for spike_train_decoder: directed scenarios plus random stimulus
// compared each cycle against an event-time based reference model.
module tb_spike_train_decoder;

   localparam int unsigned WIN    = 256;
   localparam int unsigned RATE_W = 8;
   localparam int unsigned CNT_W  = 8;
`ifdef SPIKE_DEC_ISI_EN
   localparam bit ISI_ON = 1'b1;
`else
   localparam bit ISI_ON = 1'b0;
`endif
   localparam int RATE_MAX = (1 << RATE_W) - 1;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              spike_in;
   logic              rate_ready;
   logic [RATE_W-1:0] rate_out;
   logic              rate_valid;
   logic              rate_drop;
   logic [CNT_W-1:0]  isi_out;
   logic              isi_valid;
   logic              isi_sat;

   int total = 0;
   int bad   = 0;

   // Reference model state, expressed in enabled-cycle timestamps
   bit m_spike_q;
   int en_time;
   int last_evt;
   int win_evts;
   int e_rate_out, e_rate_valid, e_rate_drop;
   int e_isi_out, e_isi_valid, e_isi_sat;

   spike_train_decoder #(
      .WIN_CYCLES(WIN), .RATE_W(RATE_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
      .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
      .rate_drop(rate_drop), .isi_out(isi_out), .isi_valid(isi_valid), .isi_sat(isi_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs after the coming clock edge, given this cycle's inputs
   task automatic model_step(input bit rst, input bit en, input bit sp, input bit rdy);
      bit evt;
      bit xfer;
      int d;
      if (rst) begin
         m_spike_q = 0; en_time = 0; last_evt = -1; win_evts = 0;
         e_rate_out = 0; e_rate_valid = 0; e_rate_drop = 0;
         e_isi_out = 0; e_isi_valid = 0; e_isi_sat = 0;
         return;
      end
      evt = sp && !m_spike_q && en;
      m_spike_q = sp;
      xfer = (e_rate_valid != 0) && rdy;
      e_isi_valid = 0;
      if (en) begin
         if (evt) begin
            win_evts++;
            if (last_evt >= 0) begin
               d = en_time - last_evt;
               e_isi_out   = (d > CNT_MAX) ? CNT_MAX : d;
               e_isi_sat   = (d >= CNT_MAX) ? 1 : 0;
               e_isi_valid = 1;
            end
            last_evt = en_time;
         end
         if ((en_time % WIN) == WIN - 1) begin
            if (e_rate_valid != 0 && !rdy) e_rate_drop = 1;
            e_rate_out   = (win_evts > RATE_MAX) ? RATE_MAX : win_evts;
            e_rate_valid = 1;
            win_evts     = 0;
         end else if (xfer) begin
            e_rate_valid = 0;
         end
         en_time++;
      end else if (xfer) begin
         e_rate_valid = 0;
      end
   endtask

   task automatic cyc(input bit rst, input bit en, input bit sp, input bit rdy);
      @(negedge clk);
      check("rate_out",   32'(rate_out),   32'(e_rate_out));
      check("rate_valid", 32'(rate_valid), 32'(e_rate_valid));
      check("rate_drop",  32'(rate_drop),  32'(e_rate_drop));
      check("isi_out",    32'(isi_out),    ISI_ON ? 32'(e_isi_out) : 32'd0);
      check("isi_valid",  32'(isi_valid),  ISI_ON ? 32'(e_isi_valid) : 32'd0);
      check("isi_sat",    32'(isi_sat),    ISI_ON ? 32'(e_isi_sat) : 32'd0);
      reset = rst; enable = en; spike_in = sp; rate_ready = rdy;
      model_step(rst, en, sp, rdy);
   endtask

   task automatic post_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit sp;
      reset = 1'b1; enable = 1'b1; spike_in = 1'b1; rate_ready = 1'b1;
      model_step(1'b1, 1'b1, 1'b1, 1'b1);

      // Reset with line high, then first released cycle is an event
      cyc(1, 1, 1, 1);
      cyc(1, 1, 1, 1);
      post_edge();
      check("rst_rate_valid", 32'(rate_valid), 32'd0);
      check("rst_isi_out", 32'(isi_out), 32'd0);
      for (int i = 0; i < 260; i++) cyc(0, 1, (i < 30) || (i == 200), 1);

      // Two isolated spikes five cycles apart
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 40; i++) begin
         cyc(0, 1, (i == 10) || (i == 15), 1);
         if (i == 10) begin
            post_edge();
            check("isi_first_none", 32'(isi_valid), 32'd0);
         end
         if (i == 15) begin
            post_edge();
            check("isi5_out", 32'(isi_out), ISI_ON ? 32'd5 : 32'd0);
            check("isi5_valid", 32'(isi_valid), ISI_ON ? 32'd1 : 32'd0);
            check("isi5_sat", 32'(isi_sat), 32'd0);
         end
      end

      // One window: 9 short pulses, one held pulse, one terminal-cycle pulse
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 256; i++) begin
         sp = ((i % 8 == 2) && (i < 74)) || (i >= 100 && i < 120) || (i == 255);
         cyc(0, 1, sp, 1);
      end
      post_edge();
      check("rate11_out", 32'(rate_out), 32'd11);
      check("rate11_valid", 32'(rate_valid), 32'd1);
      cyc(0, 1, 0, 1);
      post_edge();
      check("rate11_valid_drop", 32'(rate_valid), 32'd0);

      // Backpressure across two window closes
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 2 * 256 + 20; i++) cyc(0, 1, (i % 4 == 1) && (i < 300), 0);
      post_edge();
      check("bp_drop", 32'(rate_drop), 32'd1);
      check("bp_valid", 32'(rate_valid), 32'd1);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1);

      // Saturated interval, then a disabled stretch containing a spike
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 400; i++) begin
         sp = (i == 5) || (i == 305) || (i == 330) || (i == 331) || (i == 380);
         cyc(0, !(i >= 310 && i < 360), sp, 1);
         if (i == 305) begin
            post_edge();
            check("isi_sat_out", 32'(isi_out), ISI_ON ? 32'd255 : 32'd0);
            check("isi_sat_flag", 32'(isi_sat), ISI_ON ? 32'd1 : 32'd0);
         end
         if (i == 380) begin
            post_edge();
            check("isi_freeze_out", 32'(isi_out), ISI_ON ? 32'd25 : 32'd0);
            check("isi_freeze_sat", 32'(isi_sat), 32'd0);
         end
      end

      // Random traffic
      sp = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(2, 0) == 0) sp = ~sp;
         cyc($urandom_range(499, 0) == 0, $urandom_range(9, 0) != 0, sp,
             $urandom_range(1, 0) == 1);
      end
      cyc(0, 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spike_train_decoder.md
# spike_train_decoder

Receiving end of the neuron spike interface. It accepts a single-bit spike line from a neuron or synapse output and detects rising edges as spike events. It measures the spike rate over a fixed window and the inter-spike interval (ISI), and presents both to downstream logic, such as display or readout, in numeric form. It sits after a neuron/synapse pair in the oscillator network top level and runs in the same clock domain.

## Interface
- `WIN_CYCLES`, default 256: rate window length in clock cycles (≥2).
- `RATE_W`, default 8: width of the rate count.
- `CNT_W`, default 8: width of the ISI counter.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock for the whole block.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: when low, all counters and state freeze.
- `spike_in` input 1: spike line, synchronous to `clk`.
- `rate_out` output RATE_W: spike events counted in the last completed window.
- `rate_valid` output 1: `rate_out` holds an unconsumed result.
- `rate_ready` input 1: consumer accepts `rate_out`.
- `rate_drop` output 1: sticky; an unconsumed result was overwritten.
- `isi_out` output CNT_W: last measured inter-spike interval, in cycles.
- `isi_valid` output 1: one-cycle pulse when `isi_out` updates.
- `isi_sat` output 1: the interval reported with the current `isi_valid` was saturated.

## Operation
- Edge detect:
  - `spike_q` registers `spike_in` every cycle, including while `enable` is low.
  - `event` = `spike_in & ~spike_q & enable`.
  - A line held high yields exactly one event.
- Rate window:
  - `win_cnt` counts 0..WIN_CYCLES-1 on enabled cycles.
  - `evt_cnt` increments on each `event`, saturating at 2^RATE_W-1.
  - On an enabled edge with `win_cnt == WIN_CYCLES-1`:
    - `rate_out` <= sat(`evt_cnt` + `event`).
    - `evt_cnt` <= 0, `win_cnt` <= 0, `rate_valid` <= 1.
  - An event in the terminal cycle belongs to the closing window.
- Rate handshake:
  - Transfer occurs on an edge where `rate_valid & rate_ready`; `rate_valid` then clears.
  - If a window closes while `rate_valid=1` and `rate_ready=0`, the new value overwrites and `rate_drop` <= 1.
  - If a transfer and a window close coincide, the new value loads, `rate_valid` stays 1, and there is no drop.
  - `rate_out` is stable while `rate_valid=1`, except on overwrite.
- ISI state machine:
  - IDLE: no prior event. On `event`, go to ARMED with `isi_cnt` <= 1. No report.
  - ARMED, enabled cycle without an event: `isi_cnt` <= sat(`isi_cnt`+1), saturating at 2^CNT_W-1.
  - ARMED with `event`:
    - `isi_out` <= `isi_cnt`, `isi_valid` <= 1 for one cycle.
    - `isi_sat` <= (`isi_cnt` == 2^CNT_W-1).
    - `isi_cnt` <= 1; remain in ARMED.
  - Leaves ARMED only on `reset`.
- Enable low: `win_cnt`, `evt_cnt`, `isi_cnt` and the FSM hold. The rate handshake still completes if `rate_ready` is asserted.

## Timing
- Reset values:
  - `rate_out`=0, `rate_valid`=0, `rate_drop`=0.
  - `isi_out`=0, `isi_valid`=0, `isi_sat`=0.
  - Internal: `spike_q`=0, counters=0, FSM=IDLE.
- Reset mid-window or mid-interval discards partial counts and any pending result. A `spike_in` already high on the first post-reset cycle counts as an event.
- Event latency: an event in cycle t is counted at the edge ending cycle t.
- ISI: events at cycles t and t+N give `isi_out`=N, with `isi_valid` high in cycle t+N+1.
- Rate: `rate_valid` rises in the cycle after the terminal window cycle.
- Maximum event rate is one per 2 cycles (alternating input).

## Configuration
- Macro `SPIKE_DEC_ISI_EN`:
  - Defined: ISI counter, FSM and the `isi_*` outputs are implemented as above.
  - Undefined: ISI logic is omitted; `isi_out`=0, `isi_valid`=0 and `isi_sat`=0 permanently. Rate path is unchanged.

## Test plan
- Reset: hold `reset` 2 cycles with `spike_in`=1 → all outputs 0. First cycle after release counts one event.
- ISI: single-cycle spikes at cycles 10 and 15, `enable`=1 → `isi_out`=5 with a one-cycle `isi_valid`, `isi_sat`=0. No report for the first spike.
- Rate: `WIN_CYCLES`=256, 10 pulses plus one held-high 20-cycle pulse in a window, `rate_ready`=1 → `rate_out`=11, `rate_valid` high for 1 cycle. An event in the terminal cycle is included.
- Backpressure: `rate_ready`=0 across two window closes → `rate_out` = second count, `rate_drop`=1 (sticky). Raising `rate_ready` clears `rate_valid`.
- Saturation and freeze:
  - `CNT_W`=8, spike gap of 300 cycles → `isi_out`=255, `isi_sat`=1.
  - `enable` low for 50 cycles mid-interval → measured ISI excludes those 50 cycles.
  - A spike edge while disabled is not counted.
- Macro off: repeat the ISI scenario without `SPIKE_DEC_ISI_EN` → `isi_valid` never asserts; rate results are identical.
